// File: rtl/enemy_dir_ctrl.sv
// rtl/enemy_dir_ctrl.sv - enemy tank direction sequencer driven by the random-number block
module enemy_dir_ctrl #(
    parameter int HOLD_FRAMES = 64,
    parameter int HOLD_BITS   = 8,
    parameter int AVOID_SAME  = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic       startOfFrame,
    input  logic       collision,
    input  logic [1:0] rand_val,
    output logic       rand_req,
    output logic [1:0] direction,
    output logic       moving,
    output logic       dir_change
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SAMPLE,
        S_HOLD
    } state_t;

    localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_FRAMES[HOLD_BITS-1:0];
    localparam logic [HOLD_BITS-1:0] CNT_ONE   = {{(HOLD_BITS-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [1:0]           dir_q, dir_d;
    logic                 moving_q, moving_d;
    logic                 chg_q, chg_d;
    logic [HOLD_BITS-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic                 pend_eff;

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            dir_q    <= 2'd0;
            moving_q <= 1'b0;
            chg_q    <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            chg_q    <= chg_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        dir_d    = dir_q;
        moving_d = moving_q;
        chg_d    = 1'b0;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        pend_eff = pend_q | collision;

        if (!enable) begin
            // Abandon any request in flight; direction is kept for the next activation.
            state_d  = S_IDLE;
            moving_d = 1'b0;
            pend_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    moving_d = 1'b0;
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                end
                S_REQ: begin
                    state_d = S_SAMPLE;
                    pend_d  = pend_eff;
                end
                S_SAMPLE: begin
                    if ((AVOID_SAME != 0) && pend_eff && (rand_val == dir_q)) begin
                        dir_d = rand_val + 2'd1;
                    end else begin
                        dir_d = rand_val;
                    end
                    pend_d   = 1'b0;
                    chg_d    = 1'b1;
                    cnt_d    = HOLD_LOAD;
                    moving_d = 1'b1;
                    state_d  = S_HOLD;
                end
                S_HOLD: begin
                    moving_d = 1'b1;
                    // Collision outranks a frame tick: the counter is left untouched.
                    if (collision) begin
                        pend_d  = 1'b1;
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end else if (startOfFrame && (cnt_q != '0)) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = S_REQ;
                            req_d   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign rand_req   = req_q;
    assign direction  = dir_q;
    assign moving     = moving_q;
    assign dir_change = chg_q;

endmodule

// File: tb/tb_enemy_dir_ctrl.sv
// tb/tb_enemy_dir_ctrl.sv - scoreboard bench for enemy_dir_ctrl
module tb_enemy_dir_ctrl;

    logic       clk = 1'b0;
    logic       resetN;
    logic       enable;
    logic       sof;
    logic       collision;
    logic [1:0] rand_val;
    logic       rand_req;
    logic [1:0] direction;
    logic       moving;
    logic       dir_change;

    enemy_dir_ctrl #(
        .HOLD_FRAMES(4),
        .HOLD_BITS  (8),
        .AVOID_SAME (1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .startOfFrame(sof),
        .collision   (collision),
        .rand_val    (rand_val),
        .rand_req    (rand_req),
        .direction   (direction),
        .moving      (moving),
        .dir_change  (dir_change)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [1:0] exp_q[$];
    logic [1:0] cur_dir = 2'd0;

    logic prev_req    = 1'b0;
    int   req_pulses  = 0;
    int   req_double  = 0;

    always @(negedge clk) begin
        if (rand_req && prev_req) req_double++;
        if (rand_req && !prev_req) req_pulses++;
        prev_req = rand_req;
    end

    function automatic logic [1:0] model(input bit pend, input logic [1:0] val, input logic [1:0] cur);
        if (pend && (val == cur)) return val + 2'd1;
        return val;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_push(input bit pend, input logic [1:0] val);
        logic [1:0] e;
        e = model(pend, val, cur_dir);
        exp_q.push_back(e);
        cur_dir  = e;
        rand_val = val;
    endtask

    task automatic await_change(input int maxc, output bit seen, output int lat, output logic [1:0] exp_dir);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            lat++;
            if (dir_change) begin
                seen = 1'b1;
                break;
            end
        end
        if (exp_q.size() > 0) exp_dir = exp_q.pop_front();
        else exp_dir = 2'bxx;
    endtask

    task automatic sof_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sof = 1'b1;
            step();
            sof = 1'b0;
            repeat (9) step();
        end
    endtask

    task automatic test_reset();
        resetN = 1'b1; enable = 1'b0; sof = 1'b0; collision = 1'b0; rand_val = 2'd0;
        repeat (3) step();
        tests_run++;
        if (rand_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got=%b want=0", rand_req); end
        tests_run++;
        if (direction !== 2'd0) begin tests_failed++; $display("FAIL reset_dir got=%0d want=0", direction); end
        tests_run++;
        if (moving !== 1'b0) begin tests_failed++; $display("FAIL reset_moving got=%b want=0", moving); end
        tests_run++;
        if (dir_change !== 1'b0) begin tests_failed++; $display("FAIL reset_chg got=%b want=0", dir_change); end
    endtask

    task automatic test_first_dir();
        int         base;
        bit         seen;
        int         lat;
        logic [1:0] e;
        resetN = 1'b0;
        step();
        base = req_pulses;
        expect_push(1'b0, 2'd2);
        enable = 1'b1;
        step();
        tests_run++;
        if (rand_req !== 1'b1) begin tests_failed++; $display("FAIL first_req_high got=%b want=1", rand_req); end
        step();
        tests_run++;
        if (rand_req !== 1'b0) begin tests_failed++; $display("FAIL first_req_low got=%b want=0", rand_req); end
        await_change(4, seen, lat, e);
        tests_run++;
        if (!seen || lat != 1 || direction !== e) begin
            tests_failed++;
            $display("FAIL first_dir seen=%0d lat=%0d got=%0d want=%0d after 3 clocks", seen, lat + 2, direction, e);
        end
        tests_run++;
        if (moving !== 1'b1) begin tests_failed++; $display("FAIL first_moving got=%b want=1", moving); end
        step();
        tests_run++;
        if (dir_change !== 1'b0 || req_pulses - base != 1) begin
            tests_failed++;
            $display("FAIL first_single chg=%b pulses=%0d want chg=0 pulses=1", dir_change, req_pulses - base);
        end
    endtask

    task automatic test_hold_expiry();
        int         base;
        bit         seen;
        int         lat;
        logic [1:0] e;
        base = req_pulses;
        sof_pulses(3);
        tests_run++;
        if (req_pulses != base) begin tests_failed++; $display("FAIL hold_early_req pulses=%0d want=0", req_pulses - base); end
        expect_push(1'b0, 2'd1);
        sof = 1'b1;
        step();
        sof = 1'b0;
        tests_run++;
        if (rand_req !== 1'b1) begin tests_failed++; $display("FAIL expiry_req got=%b want=1", rand_req); end
        await_change(4, seen, lat, e);
        tests_run++;
        if (!seen || direction !== e) begin tests_failed++; $display("FAIL expiry_dir seen=%0d got=%0d want=%0d", seen, direction, e); end
    endtask

    task automatic test_avoid_same();
        logic [1:0] vals[4] = '{2'd3, 2'd3, 2'd3, 2'd1};
        bit         seen;
        int         lat;
        logic [1:0] e;
        for (int i = 0; i < 4; i++) begin
            expect_push(1'b1, vals[i]);
            collision = 1'b1;
            step();
            collision = 1'b0;
            await_change(5, seen, lat, e);
            tests_run++;
            if (!seen || direction !== e) begin
                tests_failed++;
                $display("FAIL avoid_same[%0d] seen=%0d got=%0d want=%0d", i, seen, direction, e);
            end
        end
    endtask

    task automatic test_coll_sof();
        int         base;
        bit         seen;
        int         lat;
        logic [1:0] e;
        sof_pulses(2);
        expect_push(1'b1, 2'd2);
        collision = 1'b1;
        sof = 1'b1;
        step();
        collision = 1'b0;
        sof = 1'b0;
        tests_run++;
        if (rand_req !== 1'b1) begin tests_failed++; $display("FAIL coll_sof_req got=%b want=1", rand_req); end
        await_change(4, seen, lat, e);
        tests_run++;
        if (!seen || direction !== e) begin tests_failed++; $display("FAIL coll_sof_dir seen=%0d got=%0d want=%0d", seen, direction, e); end
        base = req_pulses;
        sof_pulses(3);
        tests_run++;
        if (req_pulses != base) begin tests_failed++; $display("FAIL reload_hold pulses=%0d want=0", req_pulses - base); end
        expect_push(1'b0, 2'd0);
        sof = 1'b1;
        step();
        sof = 1'b0;
        await_change(4, seen, lat, e);
        tests_run++;
        if (!seen || direction !== e) begin tests_failed++; $display("FAIL reload_dir seen=%0d got=%0d want=%0d", seen, direction, e); end
    endtask

    task automatic test_coll_during_req();
        int         base;
        bit         seen;
        int         lat;
        logic [1:0] e;
        sof_pulses(3);
        base = req_pulses;
        expect_push(1'b1, cur_dir);
        sof = 1'b1;
        step();
        sof = 1'b0;
        collision = 1'b1;
        step();
        collision = 1'b0;
        await_change(4, seen, lat, e);
        tests_run++;
        if (!seen || direction !== e) begin tests_failed++; $display("FAIL req_coll_dir seen=%0d got=%0d want=%0d", seen, direction, e); end
        tests_run++;
        if (req_pulses - base != 1) begin tests_failed++; $display("FAIL req_coll_pulses got=%0d want=1", req_pulses - base); end
    endtask

    task automatic test_enable_abort();
        int         base;
        bit         seen;
        int         lat;
        logic [1:0] e;
        base = req_pulses;
        rand_val = cur_dir + 2'd2;
        collision = 1'b1;
        step();
        collision = 1'b0;
        enable = 1'b0;
        step();
        tests_run++;
        if (rand_req !== 1'b0 || moving !== 1'b0 || direction !== cur_dir || dir_change !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle req=%b mov=%b dir=%0d chg=%b want req=0 mov=0 dir=%0d chg=0",
                     rand_req, moving, direction, dir_change, cur_dir);
        end
        repeat (5) step();
        tests_run++;
        if (direction !== cur_dir || req_pulses - base != 1) begin
            tests_failed++;
            $display("FAIL abort_hold dir=%0d pulses=%0d want dir=%0d pulses=1", direction, req_pulses - base, cur_dir);
        end
        expect_push(1'b0, cur_dir);
        enable = 1'b1;
        await_change(5, seen, lat, e);
        tests_run++;
        if (!seen || direction !== e) begin tests_failed++; $display("FAIL pending_cleared seen=%0d got=%0d want=%0d", seen, direction, e); end
        sof_pulses(1);
        resetN = 1'b1;
        enable = 1'b0;
        step();
        resetN = 1'b0;
        cur_dir = 2'd0;
        tests_run++;
        if (direction !== 2'd0 || moving !== 1'b0 || rand_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL midhold_reset dir=%0d mov=%b req=%b want 0 0 0", direction, moving, rand_req);
        end
        base = req_pulses;
        repeat (10) step();
        tests_run++;
        if (req_pulses != base || direction !== 2'd0 || moving !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet pulses=%0d dir=%0d mov=%b want 0 0 0", req_pulses - base, direction, moving);
        end
        expect_push(1'b0, 2'd3);
        enable = 1'b1;
        await_change(6, seen, lat, e);
        tests_run++;
        if (!seen || lat != 3 || direction !== e) begin
            tests_failed++;
            $display("FAIL reenable seen=%0d lat=%0d got=%0d want lat=3 dir=%0d", seen, lat, direction, e);
        end
    endtask

    task automatic test_final();
        tests_run++;
        if (req_double != 0) begin tests_failed++; $display("FAIL req_two_cycles got=%0d want=0", req_double); end
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_first_dir();
        test_hold_expiry();
        test_avoid_same();
        test_coll_sof();
        test_coll_during_req();
        test_enable_abort();
        test_final();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/enemy_dir_ctrl.md
Name: enemy_dir_ctrl

Overview:
Drives an enemy tank's movement direction by consuming values from the random-number block. It generates the rising-edge request that the random block latches on, samples the resulting value, and holds the chosen direction for a frame-counted interval. It re-randomizes early on a collision. It sits between the random block and the enemy tank's position/motion logic in the VGA game path.

Parameters:
HOLD_FRAMES, 64, number of startOfFrame pulses a direction is held before a new request; legal range 1..2^HOLD_BITS-1.
HOLD_BITS, 8, width of the frame hold counter.
AVOID_SAME, 1, when 1, a collision-triggered draw equal to the current direction is rotated by +1 (mod 4).

Ports:
clk  in  1  system clock.
resetN  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk.
enable  in  1  tank alive and active; 0 forces IDLE.
startOfFrame  in  1  one-cycle pulse per video frame.
collision  in  1  one-cycle pulse: the tank hit a wall, brick or tank.
rand_val  in  2  random value from the random block; valid from the cycle after rand_req rises.
rand_req  out  1  request to the random block; one-cycle high pulse (rising edge = latch).
direction  out  2  current direction: 0 up, 1 right, 2 down, 3 left.
moving  out  1  1 while a valid direction is being held.
dir_change  out  1  one-cycle pulse when direction is updated.

Behaviour:
- All outputs are registered. Reset (resetN=1 at posedge) -> state IDLE, rand_req=0, direction=0, moving=0, dir_change=0, hold counter=0, collision-pending flag=0. Reset wins over every other input, including mid-request and mid-hold.
- IDLE: moving=0. If enable=1 -> REQ on the next cycle.
- REQ (exactly 1 cycle): rand_req=1. Next state is SAMPLE.
- SAMPLE (1 cycle): rand_req=0. Capture rand_val as the new direction.
  - If AVOID_SAME=1, the pending flag is set, and rand_val == current direction, then direction <= rand_val+1 (2-bit wrap, so 3 -> 0).
  - Clear the pending flag. Pulse dir_change=1. Load hold counter = HOLD_FRAMES. Go to HOLD with moving=1.
- Latency: from the enable rise (or a retrigger) to the new direction is 3 clocks: the decision cycle, REQ, and SAMPLE. direction and dir_change are visible in the cycle after SAMPLE.
- HOLD: moving=1. Each startOfFrame decrements the hold counter.
  - When the decrement reaches 0 -> REQ.
  - collision=1 -> set the pending flag and go to REQ immediately, counter ignored.
  - collision and startOfFrame in the same cycle: collision takes priority and the counter is not decremented.
- rand_req must return to 0 for at least 1 cycle between requests, so two rising edges are always separated. REQ is never entered from REQ or SAMPLE.
- collision during REQ or SAMPLE: set the pending flag only; no extra request. The flag then applies to the SAMPLE in progress.
- enable=0 in any state: next state IDLE, moving=0, rand_req=0.
  - direction holds its last value.
  - dir_change=0 and the pending flag clears.
  - A request already issued is abandoned and rand_val is not sampled.
- collision/startOfFrame in IDLE are ignored.
- Hold counter never underflows: it decrements only when nonzero and in HOLD.

Test Plan:
- Reset, then enable=1, with the random stub answering rand_val=2 the cycle after the rand_req edge -> rand_req pulses high exactly 1 cycle; direction=2, moving=1, dir_change pulses once, 3 cycles after enable.
- HOLD_FRAMES=4, 4 startOfFrame pulses spaced 10 cycles apart -> no rand_req until the 4th pulse. On the 4th, rand_req rises the next cycle and the new rand_val=1 gives direction=1.
- In HOLD with direction=3, collision pulse and stub returns 3, AVOID_SAME=1 -> direction=0 (wrap). Same stimulus with stub returning 1 -> direction=1.
- collision and startOfFrame in the same cycle with counter=2 -> immediate REQ, counter reloaded to HOLD_FRAMES after SAMPLE, not 1.
- collision pulsed during REQ -> only one rand_req pulse; SAMPLE applies avoid-same. Check rand_req is never high 2 consecutive cycles across all tests.
- enable=0 during REQ, then resetN=1 mid-HOLD -> IDLE with rand_req=0 and moving=0 the next cycle, direction held; after reset, direction=0, moving=0, and no request until enable=1.
